lpm_result_apply: RTL

- Parametrised successor to the router's LPM result-capture stage in nf10_router_output_port_lookup.
- Buffers the AXI4-Stream packet path through a small fall-through FIFO. On each packet's header beat it selects the lookup result (output queue, next hop) from an N-entry result table using the hit index from the LPM engine.
- New over the previous generation: optional rewrite of the TUSER destination-port field on the header beat, a miss-to-CPU fallback, single-beat packet support, index/queue range checks, and hit/miss/bypass counters.

---
 rtl/lpm_result_apply.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lpm_result_apply.sv
// LPM result-capture stage: a small fall-through FIFO on the packet path, a result
// table lookup on each header pop, optional TUSER destination rewrite, and packet counters.
module lpm_result_apply #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24,
  parameter int NUM_ENTRIES          = 32,
  parameter int IDX_WIDTH            = 5,
  parameter int OQ_WIDTH             = 32,
  parameter int NH_WIDTH             = 32,
  parameter int NUM_PORTS            = 4,
  parameter int FIFO_DEPTH_BITS      = 2,
  parameter int APPLY_DST            = 1
) (
  input  logic                                      AXI_ACLK,
  input  logic                                      AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]            S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]          S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]           S_AXIS_TUSER,
  input  logic                                      S_AXIS_TVALID,
  input  logic                                      S_AXIS_TLAST,
  output logic                                      S_AXIS_TREADY,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]            M_AXIS_TDATA,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          M_AXIS_TSTRB,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]           M_AXIS_TUSER,
  output logic                                      M_AXIS_TVALID,
  output logic                                      M_AXIS_TLAST,
  input  logic                                      M_AXIS_TREADY,
  input  logic [NUM_ENTRIES*(OQ_WIDTH+NH_WIDTH)-1:0] LPM_TABLE,
  input  logic                                      LPM_HIT_IN,
  input  logic [IDX_WIDTH-1:0]                      LPM_INDEX_IN,
  input  logic                                      CNT_CLEAR,
  output logic                                      lpm_hit,
  output logic [OQ_WIDTH-1:0]                       oq_reg,
  output logic [NH_WIDTH-1:0]                       nh_reg,
  output logic [31:0]                               hit_count,
  output logic [31:0]                               miss_count,
  output logic [31:0]                               bypass_count
);

  localparam int STRB_W    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << FIFO_DEPTH_BITS;
  localparam int ENTRY_W   = OQ_WIDTH + NH_WIDTH;
  localparam int TBL_SLOTS = 1 << IDX_WIDTH;
  localparam logic [FIFO_DEPTH_BITS:0] NF_LEVEL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [31:0] NUM_ENTRIES_U = 32'(NUM_ENTRIES);
  localparam logic [7:0]  CPU_MASK = (NUM_PORTS >= 4) ? 8'hAA :
                                     8'(8'hAA & ((1 << (2 * NUM_PORTS)) - 1));

  typedef enum logic {IDLE, BODY} state_t;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  data_mem_q [DEPTH];
  logic [STRB_W-1:0]               strb_mem_q [DEPTH];
  logic [C_S_AXIS_TUSER_WIDTH-1:0] user_mem_q [DEPTH];
  logic [DEPTH-1:0]                last_mem_q;

  logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
  state_t                     state_q, state_d;
  logic                       lpm_hit_q, lpm_hit_d;
  logic [OQ_WIDTH-1:0]        oq_q, oq_d;
  logic [NH_WIDTH-1:0]        nh_q, nh_d;
  logic [31:0]                hit_cnt_q, hit_cnt_d;
  logic [31:0]                miss_cnt_q, miss_cnt_d;
  logic [31:0]                byp_cnt_q, byp_cnt_d;

  logic                            push, pop, fifo_valid, nearly_full;
  logic                            head_last, is_header, is_bypass;
  logic                            idx_ok, oq_ok, valid_hit;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] head_user, out_user;
  logic [7:0]                      head_src, head_dst, new_dst;
  logic [ENTRY_W-1:0]              table_entry [TBL_SLOTS];
  logic [OQ_WIDTH-1:0]             entry_oq;
  logic [NH_WIDTH-1:0]             entry_nh;

  // Table padded to the full index range so the index selects directly; the
  // unpopulated slots read as zero and are rejected by the range check anyway.
  for (genvar g = 0; g < TBL_SLOTS; g++) begin : g_table
    if (g < NUM_ENTRIES) begin : g_used
      assign table_entry[g] = LPM_TABLE[g*ENTRY_W +: ENTRY_W];
    end else begin : g_pad
      assign table_entry[g] = '0;
    end
  end

  always_comb begin
    fifo_valid    = (count_q != '0);
    nearly_full   = (count_q >= NF_LEVEL);
    S_AXIS_TREADY = ~nearly_full & ~AXI_RESET;
    push          = S_AXIS_TVALID & S_AXIS_TREADY;
    pop           = fifo_valid & M_AXIS_TREADY;

    head_user = user_mem_q[rd_ptr_q];
    head_last = last_mem_q[rd_ptr_q];
    head_src  = head_user[SRC_PORT_POS +: 8];
    head_dst  = head_user[DST_PORT_POS +: 8];
    is_header = (state_q == IDLE);
    is_bypass = |(head_dst & CPU_MASK);

    {entry_oq, entry_nh} = table_entry[LPM_INDEX_IN];
    idx_ok    = (32'(LPM_INDEX_IN) < NUM_ENTRIES_U);
    oq_ok     = (entry_oq < OQ_WIDTH'(NUM_PORTS));
    valid_hit = LPM_HIT_IN & idx_ok & oq_ok;
    new_dst   = valid_hit ? (8'd1 << {entry_oq[1:0], 1'b0}) : {head_src[6:0], 1'b0};

    out_user = head_user;
    if ((APPLY_DST != 0) && is_header && !is_bypass) begin
      out_user[DST_PORT_POS +: 8] = new_dst;
    end

    M_AXIS_TVALID = fifo_valid;
    M_AXIS_TDATA  = fifo_valid ? data_mem_q[rd_ptr_q] : '0;
    M_AXIS_TSTRB  = fifo_valid ? strb_mem_q[rd_ptr_q] : '0;
    M_AXIS_TUSER  = fifo_valid ? out_user : '0;
    M_AXIS_TLAST  = fifo_valid & head_last;
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    lpm_hit_d  = lpm_hit_q;
    oq_d       = oq_q;
    nh_d       = nh_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    byp_cnt_d  = byp_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Both states leave on TLAST and otherwise land in BODY, so the next
    // state depends only on the popped beat's TLAST.
    if (pop) state_d = head_last ? IDLE : BODY;

    if (pop && is_header) begin
      if (is_bypass) begin
        byp_cnt_d = byp_cnt_q + 32'd1;
      end else if (valid_hit) begin
        lpm_hit_d = 1'b1;
        oq_d      = entry_oq;
        nh_d      = entry_nh;
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        lpm_hit_d  = 1'b0;
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end

    if (CNT_CLEAR) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      byp_cnt_d  = '0;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      lpm_hit_q  <= 1'b0;
      oq_q       <= '0;
      nh_q       <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      byp_cnt_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      lpm_hit_q  <= lpm_hit_d;
      oq_q       <= oq_d;
      nh_q       <= nh_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      byp_cnt_q  <= byp_cnt_d;
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= S_AXIS_TDATA;
      strb_mem_q[wr_ptr_q] <= S_AXIS_TSTRB;
      user_mem_q[wr_ptr_q] <= S_AXIS_TUSER;
      last_mem_q[wr_ptr_q] <= S_AXIS_TLAST;
    end
  end

  always_comb begin
    lpm_hit      = lpm_hit_q;
    oq_reg       = oq_q;
    nh_reg       = nh_q;
    hit_count    = hit_cnt_q;
    miss_count   = miss_cnt_q;
    bypass_count = byp_cnt_q;
  end

endmodule
